detect_n_ones: RTL and testbench

//   Parametrised run detector: asserts dout when N consecutive 1s arrive on din.

---
 rtl/detect_n_ones.sv | 64 ++++++
 tb/tb_detect_n_ones.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/detect_n_ones.sv
// rtl/detect_n_ones.sv - run detector for N consecutive qualified 1s with saturating hit counter
module detect_n_ones #(
    parameter int N  = 3,
    parameter int RW = 8,
    parameter int CW = 8
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          din,
    input  logic          en,
    input  logic          mode,
    input  logic          clr,
    output logic          dout,
    output logic [RW-1:0] run,
    output logic [CW-1:0] hits,
    output logic          hit_sat
);

    localparam logic [RW-1:0] N_V   = RW'(N);
    localparam logic [RW-1:0] N_M1  = RW'(N - 1);
    localparam logic [CW-1:0] H_MAX = '1;

    logic          match;
    logic [RW-1:0] run_nx;
    logic [CW-1:0] hits_nx;

    assign match = en && din && (run >= N_M1);

    always_comb begin
        run_nx  = run;
        hits_nx = hits;
        if (clr) begin
            run_nx  = '0;
            hits_nx = '0;
        end else if (en) begin
            if (!din) begin
                run_nx = '0;
            end else if (mode) begin
                run_nx = match ? '0 : run + RW'(1);
            end else begin
                // Overlapping mode parks the run at N so every further 1 keeps matching.
                run_nx = (run >= N_V) ? N_V : run + RW'(1);
            end
            if (match && (hits != H_MAX)) begin
                hits_nx = hits + CW'(1);
            end
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            run     <= '0;
            hits    <= '0;
            hit_sat <= 1'b0;
            dout    <= 1'b0;
        end else begin
            run     <= run_nx;
            hits    <= hits_nx;
            hit_sat <= (hits_nx == H_MAX);
            dout    <= match && !clr;
        end
    end

endmodule

// File: tb/tb_detect_n_ones.sv
// tb/tb_detect_n_ones.sv - directed bench for detect_n_ones with per-cycle reference model
module tb_detect_n_ones;

    logic ck = 1'b0;
    logic rst, din, en, mode, clr;

    logic       dout_w   [4];
    logic [7:0] run_w    [4];
    logic [7:0] hits_w   [4];
    logic       sat_w    [4];
    logic [2:0] hits_c3;

    int n_vec = 0;
    int n_err = 0;

    // Instance parameters: index 0..3 -> N=2, N=3, N=1 (CW=3), N=4
    int nv  [4] = '{2, 3, 1, 4};
    int hmx [4] = '{255, 255, 7, 255};

    always #5 ck = ~ck;

    detect_n_ones #(.N(2), .RW(8), .CW(8)) u_n2 (.ck(ck), .rst(rst), .din(din), .en(en), .mode(mode), .clr(clr),
        .dout(dout_w[0]), .run(run_w[0]), .hits(hits_w[0]), .hit_sat(sat_w[0]));
    detect_n_ones #(.N(3), .RW(8), .CW(8)) u_n3 (.ck(ck), .rst(rst), .din(din), .en(en), .mode(mode), .clr(clr),
        .dout(dout_w[1]), .run(run_w[1]), .hits(hits_w[1]), .hit_sat(sat_w[1]));
    detect_n_ones #(.N(1), .RW(8), .CW(3)) u_n1 (.ck(ck), .rst(rst), .din(din), .en(en), .mode(mode), .clr(clr),
        .dout(dout_w[2]), .run(run_w[2]), .hits(hits_c3), .hit_sat(sat_w[2]));
    detect_n_ones #(.N(4), .RW(8), .CW(8)) u_n4 (.ck(ck), .rst(rst), .din(din), .en(en), .mode(mode), .clr(clr),
        .dout(dout_w[3]), .run(run_w[3]), .hits(hits_w[3]), .hit_sat(sat_w[3]));

    assign hits_w[2] = {5'b0, hits_c3};

    // Model: cnt is an unbounded count of 1s since the last break (or last
    // non-overlapping match); tot is the unbounded number of matches.
    int cnt [4];
    int tot [4];
    bit mdo [4];

    always @(posedge ck or negedge rst) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst || clr) begin
                cnt[i] = 0;
                tot[i] = 0;
                mdo[i] = 1'b0;
            end else if (!en) begin
                mdo[i] = 1'b0;
            end else if (!din) begin
                cnt[i] = 0;
                mdo[i] = 1'b0;
            end else begin
                mdo[i] = (cnt[i] + 1 >= nv[i]);
                if (mdo[i]) tot[i] = tot[i] + 1;
                cnt[i] = (mode && mdo[i]) ? 0 : cnt[i] + 1;
            end
        end
    end

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    always @(negedge ck) begin
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (dout_w[i] !== mdo[i] || run_w[i] !== 8'(min2(cnt[i], nv[i])) ||
                hits_w[i] !== 8'(min2(tot[i], hmx[i])) || sat_w[i] !== (tot[i] >= hmx[i])) begin
                n_err++;
                $display("FAIL model inst%0d t=%0t: dout=%0b run=%0d hits=%0d sat=%0b, required dout=%0b run=%0d hits=%0d sat=%0b",
                         i, $time, dout_w[i], run_w[i], hits_w[i], sat_w[i],
                         mdo[i], min2(cnt[i], nv[i]), min2(tot[i], hmx[i]), tot[i] >= hmx[i]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic apply(input bit d, input bit e, input bit m, input bit c);
        din  = d;
        en   = e;
        mode = m;
        clr  = c;
        @(posedge ck);
        #1;
    endtask

    task automatic clear_all();
        apply(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bit t1_din [7] = '{0, 1, 1, 1, 0, 1, 1};
        bit t1_exp [7] = '{0, 0, 1, 1, 0, 0, 1};
        bit t2_exp [7] = '{0, 0, 1, 0, 0, 1, 0};
        bit t3_en  [5] = '{1, 0, 0, 1, 1};
        bit t3_exp [5] = '{0, 0, 0, 0, 1};

        rst = 1'b0; din = 1'b1; en = 1'b1; mode = 1'b0; clr = 1'b0;
        @(posedge ck); #1;
        @(posedge ck); #1;
        chk("reset_run", run_w[1], 0);
        chk("reset_dout", dout_w[1], 0);
        chk("reset_hits", hits_w[1], 0);
        chk("reset_sat", sat_w[2], 0);
        #2 rst = 1'b1;

        // 1: N=2 overlapping
        clear_all();
        for (int k = 0; k < 7; k++) begin
            apply(t1_din[k], 1'b1, 1'b0, 1'b0);
            chk($sformatf("t1_dout%0d", k), dout_w[0], t1_exp[k]);
        end
        chk("t1_hits", hits_w[0], 3);
        chk("t1_run", run_w[0], 2);

        // 2: N=3 non-overlapping
        clear_all();
        for (int k = 0; k < 7; k++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b0);
            chk($sformatf("t2_dout%0d", k), dout_w[1], t2_exp[k]);
        end
        chk("t2_hits", hits_w[1], 2);
        chk("t2_run", run_w[1], 1);

        // 3: N=3, en bubbles hold the run
        clear_all();
        for (int k = 0; k < 5; k++) begin
            apply(1'b1, t3_en[k], 1'b0, 1'b0);
            chk($sformatf("t3_dout%0d", k), dout_w[1], t3_exp[k]);
            if (k == 2) chk("t3_run_hold", run_w[1], 1);
        end

        // 4: clr overrides an enabled 1
        clear_all();
        apply(1'b1, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t4_run", run_w[1], 0);
        chk("t4_dout", dout_w[1], 0);
        chk("t4_hits", hits_w[1], 0);
        apply(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_dout_a", dout_w[1], 0);
        apply(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_dout_b", dout_w[1], 0);

        // 5: N=1, CW=3 saturation
        clear_all();
        for (int k = 1; k <= 9; k++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0);
            chk($sformatf("t5_dout%0d", k), dout_w[2], 1);
            chk($sformatf("t5_hits%0d", k), hits_w[2], (k < 7) ? k : 7);
            chk($sformatf("t5_sat%0d", k), sat_w[2], (k >= 7) ? 1 : 0);
        end
        chk("t5_run_m0", run_w[2], 1);
        apply(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t5_run_m1", run_w[2], 0);
        chk("t5_hits_hold", hits_w[2], 7);

        // mode change: saturated R from mode 0 matches in mode 1 and resets
        clear_all();
        for (int k = 0; k < 4; k++) apply(1'b1, 1'b1, 1'b0, 1'b0);
        chk("mc_run_sat", run_w[1], 3);
        apply(1'b1, 1'b1, 1'b1, 1'b0);
        chk("mc_dout", dout_w[1], 1);
        chk("mc_run", run_w[1], 0);

        // 6: N=4, async reset mid-run
        clear_all();
        for (int k = 0; k < 3; k++) apply(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_run_pre", run_w[3], 3);
        #2 rst = 1'b0;
        #1;
        chk("t6_run_rst", run_w[3], 0);
        chk("t6_dout_rst", dout_w[3], 0);
        chk("t6_hits_rst", hits_w[1], 0);
        @(posedge ck); #1;
        chk("t6_run_held", run_w[3], 0);
        #2 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0);
            chk($sformatf("t6_dout%0d", k), dout_w[3], (k == 3) ? 1 : 0);
        end
        chk("t6_hits", hits_w[3], 1);

        apply(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge ck);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
